// File: rtl/psp_pkg.sv
// Shared types and widths for the PSP two-port memory arbiter.
package psp_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  // Request as presented on the shared backing port
  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/psp_mem_arbiter_if.sv
// Memory request/response port: master issues requests, slave answers them.
interface psp_mem_arbiter_if;

  logic                      read;
  logic                      write;
  logic [psp_pkg::ADDR_W-1:0] addr;
  logic [psp_pkg::DATA_W-1:0] wdata;
  logic [psp_pkg::MASK_W-1:0] wmask;
  logic [psp_pkg::DATA_W-1:0] rdata;
  logic                      resp;

  modport master (
    output read, write, addr, wdata, wmask,
    input  rdata, resp
  );

  modport slave (
    input  read, write, addr, wdata, wmask,
    output rdata, resp
  );

endinterface

// File: rtl/psp_arb_watchdog.sv
// Counts cycles a granted transaction has been waiting; flags expiry at TIMEOUT-1.
module psp_arb_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT) > 16) ? $clog2(TIMEOUT) : 16;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Clear on grant, count while granted, saturate at the limit so expiry holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/psp_mem_arbiter.sv
// Shares one backing memory port between instruction fetch (imem) and load/store (dmem).
// Optional build macro: PSP_ARB_RR_EN selects round-robin tie-break instead of fixed dmem priority.
module psp_mem_arbiter
  import psp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  psp_mem_arbiter_if.slave  imem,
  psp_mem_arbiter_if.slave  dmem,
  psp_mem_arbiter_if.master mem,
  output logic              err
);

  arb_state_t state_q, state_d;
  mem_req_t   req_q, req_d;
  logic       err_q, err_d;
  logic       want_i, want_d, pick_d;
  logic       wd_clear, wd_expired;
`ifdef PSP_ARB_RR_EN
  arb_port_t  last_q, last_d;
`endif

  // imem is read-only; its write-side signals carry no meaning here
  logic unused_imem;
  assign unused_imem = ^{imem.write, imem.wdata, imem.wmask};

  psp_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (state_q != IDLE),
    .expired(wd_expired)
  );

  // Winner selection: dmem by default, alternate on ties when round-robin is built in
  always_comb begin
    want_i = imem.read;
    want_d = dmem.read || dmem.write;
`ifdef PSP_ARB_RR_EN
    pick_d = want_d && (!want_i || (last_q == PORT_I));
`else
    pick_d = want_d;
`endif
  end

  // Next-state, backing-port request and sticky error
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    err_d    = err_q;
    wd_clear = 1'b0;
`ifdef PSP_ARB_RR_EN
    last_d   = last_q;
`endif

    if (dmem.read && dmem.write) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (mem.resp) err_d = 1'b1;
        if (pick_d) begin
          state_d     = GRANT_D;
          req_d.read  = dmem.read && !dmem.write;
          req_d.write = dmem.write;
          req_d.addr  = dmem.addr;
          req_d.wdata = dmem.wdata;
          req_d.wmask = dmem.wmask;
          wd_clear    = 1'b1;
`ifdef PSP_ARB_RR_EN
          last_d      = PORT_D;
`endif
        end else if (want_i) begin
          state_d     = GRANT_I;
          req_d.read  = 1'b1;
          req_d.write = 1'b0;
          req_d.addr  = imem.addr;
          req_d.wdata = '0;
          req_d.wmask = '0;
          wd_clear    = 1'b1;
`ifdef PSP_ARB_RR_EN
          last_d      = PORT_I;
`endif
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem.resp) begin
          state_d     = IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
        end else if (wd_expired) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
`ifdef PSP_ARB_RR_EN
      last_q  <= PORT_I;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
`ifdef PSP_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Response routing: completion goes to the granted requester in the same cycle
  always_comb begin
    imem.rdata = mem.rdata;
    dmem.rdata = mem.rdata;
    imem.resp  = mem.resp && (state_q == GRANT_I);
    dmem.resp  = mem.resp && (state_q == GRANT_D);
  end

  assign mem.read  = req_q.read;
  assign mem.write = req_q.write;
  assign mem.addr  = req_q.addr;
  assign mem.wdata = req_q.wdata;
  assign mem.wmask = req_q.wmask;
  assign err       = err_q;

endmodule

// File: tb/tb_psp_mem_arbiter.sv
// Bench for psp_mem_arbiter: transaction-level model plus directed scenarios.
module tb_psp_mem_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  logic err;
  logic [31:0] mem_data;

  psp_mem_arbiter_if imem_if ();
  psp_mem_arbiter_if dmem_if ();
  psp_mem_arbiter_if mem_if ();

  psp_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .imem (imem_if),
    .dmem (dmem_if),
    .mem  (mem_if),
    .err  (err)
  );

  always #5 clk = ~clk;

  assign mem_if.rdata = mem_data;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: one outstanding transaction on the shared port at a time
  bit          m_busy, m_on_d, m_read, m_write, m_err, m_last_d;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  int unsigned m_wait;

  wire want_i = imem_if.read;
  wire want_d = dmem_if.read || dmem_if.write;
`ifdef PSP_ARB_RR_EN
  wire tie_to_d = !m_last_d;
`else
  wire tie_to_d = 1'b1;
`endif
  wire take_d = want_d && (!want_i || tie_to_d);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_on_d <= 0; m_read <= 0; m_write <= 0; m_err <= 0; m_last_d <= 0;
      m_addr <= '0; m_wdata <= '0; m_mask <= '0; m_wait <= 0;
    end else begin
      if (dmem_if.read && dmem_if.write) m_err <= 1;
      if (!m_busy) begin
        if (mem_if.resp) m_err <= 1;
        if (want_i || want_d) begin
          m_busy <= 1; m_on_d <= take_d; m_last_d <= take_d; m_wait <= 0;
          if (take_d) begin
            m_write <= dmem_if.write;
            m_read  <= dmem_if.read && !dmem_if.write;
            m_addr  <= dmem_if.addr; m_wdata <= dmem_if.wdata; m_mask <= dmem_if.wmask;
          end else begin
            m_read <= 1; m_write <= 0;
            m_addr <= imem_if.addr; m_wdata <= '0; m_mask <= '0;
          end
        end
      end else if (mem_if.resp) begin
        m_busy <= 0; m_read <= 0; m_write <= 0;
      end else begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 == TIMEOUT) m_err <= 1;
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("mem_read",  32'(mem_if.read),  32'(m_read));
      chk("mem_write", 32'(mem_if.write), 32'(m_write));
      chk("mem_addr",  mem_if.addr,       m_addr);
      chk("mem_wdata", mem_if.wdata,      m_wdata);
      chk("mem_wmask", 32'(mem_if.wmask), 32'(m_mask));
      chk("err",       32'(err),          32'(m_err));
      chk("imem_resp", 32'(imem_if.resp), 32'(m_busy && !m_on_d && mem_if.resp));
      chk("dmem_resp", 32'(dmem_if.resp), 32'(m_busy && m_on_d && mem_if.resp));
      if (m_busy && mem_if.resp) begin
        if (m_on_d) chk("dmem_rdata", dmem_if.rdata, mem_data);
        else        chk("imem_rdata", imem_if.rdata, mem_data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    imem_if.read = 0; imem_if.write = 0; imem_if.addr = '0; imem_if.wdata = '0; imem_if.wmask = '0;
    dmem_if.read = 0; dmem_if.write = 0; dmem_if.addr = '0; dmem_if.wdata = '0; dmem_if.wmask = '0;
    mem_if.resp = 0; mem_data = '0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read",  32'(mem_if.read), 0);
    chk("rst_mem_write", 32'(mem_if.write), 0);
    chk("rst_mem_addr",  mem_if.addr, 0);
    chk("rst_err",       32'(err), 0);
    chk("rst_imem_resp", 32'(imem_if.resp), 0);
    chk("rst_dmem_resp", 32'(dmem_if.resp), 0);
    reset = 0;
    tick();

    // Single fetch, memory answers three cycles after the request
    imem_if.read = 1; imem_if.addr = 32'h60;
    tick(); #1;
    chk("t1_mem_read", 32'(mem_if.read), 1);
    chk("t1_mem_addr", mem_if.addr, 32'h60);
    chk("t1_mem_wmask", 32'(mem_if.wmask), 0);
    chk("t1_mem_write", 32'(mem_if.write), 0);
    tick(); tick();
    mem_data = 32'h0000_0013; mem_if.resp = 1; #1;
    chk("t1_imem_resp", 32'(imem_if.resp), 1);
    chk("t1_imem_rdata", imem_if.rdata, 32'h0000_0013);
    chk("t1_dmem_resp", 32'(dmem_if.resp), 0);
    tick();
    mem_if.resp = 0; imem_if.read = 0; #1;
    chk("t1_mem_read_low", 32'(mem_if.read), 0);
    chk("t1_imem_resp_low", 32'(imem_if.resp), 0);
    tick();

    // Simultaneous requests: dmem first, then a second tie at r+1
    imem_if.read = 1; imem_if.addr = 32'h100;
    dmem_if.write = 1; dmem_if.addr = 32'h2000; dmem_if.wdata = 32'hDEAD_BEEF; dmem_if.wmask = 4'hF;
    tick(); #1;
    chk("t2_mem_write", 32'(mem_if.write), 1);
    chk("t2_mem_read", 32'(mem_if.read), 0);
    chk("t2_mem_addr", mem_if.addr, 32'h2000);
    chk("t2_mem_wdata", mem_if.wdata, 32'hDEAD_BEEF);
    chk("t2_mem_wmask", 32'(mem_if.wmask), 32'hF);
    mem_data = 32'h0; mem_if.resp = 1; #1;
    chk("t2_dmem_resp", 32'(dmem_if.resp), 1);
    chk("t2_imem_resp", 32'(imem_if.resp), 0);
    tick();
    mem_if.resp = 0;
    dmem_if.addr = 32'h2004; dmem_if.wdata = 32'h1234_5678; dmem_if.wmask = 4'h3;
    tick(); #1;
`ifdef PSP_ARB_RR_EN
    chk("t2_tie2_imem_read", 32'(mem_if.read), 1);
    chk("t2_tie2_addr", mem_if.addr, 32'h100);
    mem_data = 32'hCAFE_0001; mem_if.resp = 1; #1;
    chk("t2_tie2_imem_resp", 32'(imem_if.resp), 1);
    tick();
    mem_if.resp = 0; imem_if.read = 0;
    tick(); #1;
    chk("t2_late_dmem_write", 32'(mem_if.write), 1);
    chk("t2_late_addr", mem_if.addr, 32'h2004);
    mem_if.resp = 1; #1;
    chk("t2_late_dmem_resp", 32'(dmem_if.resp), 1);
`else
    chk("t2_tie2_dmem_write", 32'(mem_if.write), 1);
    chk("t2_tie2_addr", mem_if.addr, 32'h2004);
    mem_if.resp = 1; #1;
    chk("t2_tie2_dmem_resp", 32'(dmem_if.resp), 1);
    tick();
    mem_if.resp = 0; dmem_if.write = 0;
    tick(); #1;
    chk("t2_late_imem_read", 32'(mem_if.read), 1);
    chk("t2_late_addr", mem_if.addr, 32'h100);
    mem_data = 32'hCAFE_0001; mem_if.resp = 1; #1;
    chk("t2_late_imem_resp", 32'(imem_if.resp), 1);
`endif
    tick();
    mem_if.resp = 0; imem_if.read = 0; dmem_if.write = 0;
    dmem_if.wdata = '0; dmem_if.wmask = '0;
    tick();

    // Back-to-back dmem loads with a one-cycle memory
    dmem_if.read = 1; dmem_if.addr = 32'h10;
    tick(); #1;
    chk("t3_load1_read", 32'(mem_if.read), 1);
    chk("t3_load1_addr", mem_if.addr, 32'h10);
    mem_data = 32'h1111_1111; mem_if.resp = 1; #1;
    chk("t3_load1_resp", 32'(dmem_if.resp), 1);
    chk("t3_load1_rdata", dmem_if.rdata, 32'h1111_1111);
    tick();
    mem_if.resp = 0; dmem_if.addr = 32'h14; #1;
    chk("t3_gap_read", 32'(mem_if.read), 0);
    tick(); #1;
    chk("t3_load2_read", 32'(mem_if.read), 1);
    chk("t3_load2_addr", mem_if.addr, 32'h14);
    mem_data = 32'h2222_2222; mem_if.resp = 1; #1;
    chk("t3_load2_resp", 32'(dmem_if.resp), 1);
    chk("t3_load2_rdata", dmem_if.rdata, 32'h2222_2222);
    tick();
    mem_if.resp = 0; dmem_if.read = 0;
    tick();

    // Watchdog: no response for TIMEOUT cycles after the grant
    imem_if.read = 1; imem_if.addr = 32'h200;
    tick(); #1;
    chk("t4_err_at_grant", 32'(err), 0);
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      tick(); #1;
      chk("t4_err_before_timeout", 32'(err), 0);
    end
    tick(); #1;
    chk("t4_err_at_timeout", 32'(err), 1);
    chk("t4_still_waiting", 32'(mem_if.read), 1);
    mem_data = 32'h0000_ABCD; mem_if.resp = 1; #1;
    chk("t4_late_resp", 32'(imem_if.resp), 1);
    tick();
    mem_if.resp = 0; imem_if.read = 0; #1;
    chk("t4_err_sticky", 32'(err), 1);
    tick();

    // Reset during a dmem write with an imem fetch pending
    dmem_if.write = 1; dmem_if.addr = 32'h3000; dmem_if.wdata = 32'h55; dmem_if.wmask = 4'h3;
    imem_if.read = 1; imem_if.addr = 32'h400;
    tick(); #1;
    chk("t5_mem_write", 32'(mem_if.write), 1);
    #1 reset = 1; #1;
    chk("t5_rst_mem_write", 32'(mem_if.write), 0);
    chk("t5_rst_mem_read", 32'(mem_if.read), 0);
    chk("t5_rst_mem_addr", mem_if.addr, 0);
    chk("t5_rst_mem_wdata", mem_if.wdata, 0);
    chk("t5_rst_err", 32'(err), 0);
    chk("t5_rst_dmem_resp", 32'(dmem_if.resp), 0);
    chk("t5_rst_imem_resp", 32'(imem_if.resp), 0);
    dmem_if.write = 0; dmem_if.wdata = '0; dmem_if.wmask = '0;
    tick();
    reset = 0;
    tick(); #1;
    chk("t5_post_imem_read", 32'(mem_if.read), 1);
    chk("t5_post_addr", mem_if.addr, 32'h400);
    mem_data = 32'h4444_0000; mem_if.resp = 1; #1;
    chk("t5_post_resp", 32'(imem_if.resp), 1);
    tick();
    mem_if.resp = 0; imem_if.read = 0;
    tick();

    // Read and write together: protocol error, issued as a write
    dmem_if.read = 1; dmem_if.write = 1; dmem_if.addr = 32'h500; dmem_if.wdata = 32'h77; dmem_if.wmask = 4'h1;
    tick(); #1;
    chk("t6_mem_write", 32'(mem_if.write), 1);
    chk("t6_mem_read", 32'(mem_if.read), 0);
    chk("t6_err", 32'(err), 1);
    mem_if.resp = 1; #1;
    chk("t6_dmem_resp", 32'(dmem_if.resp), 1);
    tick();
    mem_if.resp = 0; dmem_if.read = 0; dmem_if.write = 0;
    tick();

    // Stray memory response while idle
    reset = 1;
    tick();
    reset = 0; #1;
    chk("t7_err_cleared", 32'(err), 0);
    mem_if.resp = 1;
    tick();
    mem_if.resp = 0; #1;
    chk("t7_err_stray", 32'(err), 1);
    chk("t7_no_issue", 32'(mem_if.read), 0);
    tick(); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/psp_mem_arbiter.md
# psp_mem_arbiter

Two-port to one-port memory arbiter for the PSP core. Shares a single backing memory port between the instruction-fetch requester (imem) and the load/store requester (dmem). Sits between the PSP pipeline's memory interfaces and the unified memory model or cache. Provides registered request outputs, a response-routing path and a sticky watchdog error for the top-level bench to observe.

## Interface
- TIMEOUT, default 1024: cycles a granted transaction may wait for mem_resp before err is raised.
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_read  input  1  fetch request, held until imem_resp
- imem_addr  input  32  fetch address, stable while imem_read
- imem_rdata  output  32  fetch data, valid when imem_resp
- imem_resp  output  1  one-cycle fetch completion
- dmem_read / dmem_write  input  1 / 1  data request, held until dmem_resp
- dmem_addr  input  32  data address
- dmem_wdata  input  32  store data
- dmem_wmask  input  4  store byte enables
- dmem_rdata  output  32  load data, valid when dmem_resp
- dmem_resp  output  1  one-cycle data completion
- mem_read / mem_write  output  1 / 1  backing-port request (registered)
- mem_addr, mem_wdata  output  32 / 32  backing-port address/data (registered)
- mem_wmask  output  4  backing-port byte enables (registered)
- mem_rdata  input  32  backing-port read data
- mem_resp  input  1  backing-port one-cycle completion
- err  output  1  sticky: timeout or protocol violation

## Operation
- States: IDLE, GRANT_I, GRANT_D.
- IDLE: if any request, select winner, latch its addr/wdata/wmask/op into mem_* registers, go to GRANT_I or GRANT_D.
- Tie (imem_read and dmem request same cycle): dmem wins (fixed priority).
- GRANT_x: hold mem_* constant. On mem_resp: route mem_rdata to granted requester's rdata, pulse its resp combinationally in the same cycle, clear mem_read/mem_write at edge, return to IDLE.
- Non-granted resp is always 0; non-granted rdata is don't-care (driven from mem_rdata).
- imem writes never issued; imem mem_wmask = 4'b0000.
- dmem_read && dmem_write both high: protocol error, err set, treated as write.
- Watchdog: 16-bit-or-wider counter clears on grant, increments in GRANT_x; at TIMEOUT-1 without mem_resp, err sets. Transaction keeps waiting (no abort).
- mem_resp in IDLE: ignored, err set.
- Reset (any time, incl. mid-transaction): state IDLE, mem_read=mem_write=0, mem_addr/mem_wdata=0, mem_wmask=0, imem_resp=dmem_resp=0, err=0, counter=0, last-grant=IMEM.

## Timing
- Request seen in IDLE at cycle t -> mem_read/mem_write high at t+1.
- mem_resp at cycle r -> requester resp at cycle r; mem_* request low at r+1; IDLE at r+1.
- Requester drops request at r+1; a new request at r+1 is granted at edge r+1, issued at r+2.
- Minimum per-transaction occupancy: 2 cycles (grant + 1-cycle memory). Back-to-back throughput: 1 transaction per 2 cycles minimum.
- err rises one cycle after the triggering condition, holds until reset.

## Configuration
- PSP_ARB_RR_EN defined: tie-break is round-robin using last-grant register (reset IMEM, so first tie goes to dmem, next tie to imem, alternating). Last-grant updates on every grant.
- Undefined: fixed dmem priority; last-grant register absent.

## Structure
- psp_pkg: arb_state_t enum (IDLE, GRANT_I, GRANT_D), arb_port_t enum (PORT_I, PORT_D), width constants (ADDR_W=32, DATA_W=32, MASK_W=4).
- One sub-module: psp_arb_watchdog (counter plus compare, inputs clk/reset/clear/enable, output expired).
- Arbiter FSM and mux logic stay in psp_mem_arbiter.

## Test plan
- Single fetch: imem_read, addr 0x60, memory responds 3 cycles later with 0x00000013 -> mem_read at t+1, imem_resp one cycle with imem_rdata 0x00000013, dmem_resp 0.
- Simultaneous: imem addr 0x100, dmem write 0x2000/0xDEADBEEF/mask 0xF at same cycle -> dmem served first, then imem; with PSP_ARB_RR_EN, repeat the tie and imem wins the second tie.
- Back-to-back dmem loads to 0x10, 0x14 with 1-cycle memory -> mem_read high cycles t+1 and t+3, two dmem_resp pulses with correct data.
- Timeout: grant, mem_resp held low TIMEOUT cycles -> err high at grant+TIMEOUT; late mem_resp still completes the transaction; err stays high.
- Reset mid-transaction: assert reset during GRANT_D -> mem_write drops immediately (async), all resp 0, err 0; after release, pending imem_read is granted normally.
- Protocol: dmem_read and dmem_write both high -> err set, mem_write issued, mem_read 0.
